seq_match_sched: RTL and testbench
==================================

# seq_match_sched

Round-robin scheduler sharing one overlapping "1010" Moore sequence detector among NREQ requesters. Each requester hands over a parallel word through a valid/ready handshake. The block serializes the word MSB-first through the embedded detector, counts overlapping matches, and returns the count tagged with the requester index. It sits between the parallel word sources and the result consumer.

## Interface
- NREQ, 4, number of requesters (2..8)
- WORD_W, 8, bits per word
- CNT_W, 4, match-count width; the count saturates at 2^CNT_W-1
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*WORD_W  word of requester i at bits [i*WORD_W +: WORD_W]
- req_ready  out  NREQ  one-hot accept; asserted only in IDLE, only for the winner
- res_valid  out  1  result valid
- res_id  out  clog2(NREQ)  index of the requester served
- res_count  out  CNT_W  number of matches in the word
- res_ready  in  1  consumer accepts the result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE:
    - Winner is the first asserted req_valid at or after rr_ptr, searching with wrap.
    - req_ready[winner] is combinational in IDLE.
    - On handshake: capture word and id, detector state=S0, count=0, bit index=WORD_W-1, rr_ptr=winner+1 mod NREQ, go to SHIFT.
  - SHIFT: one bit per cycle, MSB first. After WORD_W cycles, go to FLUSH.
  - FLUSH: one cycle that samples the detector output for the last bit. Then go to RESP.
  - RESP: res_valid=1. res_id and res_count are held stable until res_ready. Then go to IDLE.
- Detector (internal):
  - States S0..S4.
  - Transitions:
    - S0: 1→S1, 0→S0
    - S1: 1→S1, 0→S2
    - S2: 1→S3, 0→S0
    - S3: 1→S1, 0→S4
    - S4: 1→S3, 0→S0
  - Match output = (state==S4).
  - The detector advances only in SHIFT.
  - The detector is cleared to S0 at every capture, so there is no overlap across words.
- Counting: on every SHIFT and FLUSH clock edge where the detector state==S4, count increments, saturating at max.
- Arbitration:
  - No requester waits more than NREQ-1 grants.
  - req_valid of non-winners is ignored.
  - req_data is sampled only on the handshake edge.
- No new word is accepted outside IDLE.

## Timing
- Handshake edge T0. SHIFT occupies T0+1..T0+WORD_W. FLUSH is T0+WORD_W+1. res_valid rises at T0+WORD_W+2.
- Minimum accept-to-accept spacing is WORD_W+3 cycles, when res_ready=1.
- When res_ready is high in the first RESP cycle, the result handshakes there and IDLE grants on the next cycle.
- res_valid has no combinational path from res_ready.
- Reset values: state IDLE, rr_ptr=0, req_ready=0 during the reset cycle, res_valid=0, res_id=0, res_count=0, busy=0.
  - Total counter is 0 when enabled.
- Reset mid-operation: the word in flight is dropped, no result is produced, and rr_ptr returns to 0.
- Simultaneous valids: exactly one req_ready bit is set, chosen per rr_ptr.
- Count-width rule: 8-bit words give at most 3 matches (e.g. 0xAA), so CNT_W=4 never saturates. Saturation matters only for larger WORD_W.

## Configuration
- SEQ_MATCH_SCHED_TOTAL_EN defined: adds an output total_matches, 16 bits wide.
  - It accumulates res_count on each result handshake.
  - It saturates at 0xFFFF and resets to 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Req 0 sends 0xAA with res_ready=1 → res_valid at T0+10, res_id=0, res_count=3.
- Req 1 sends 0x0A → res_count=1. Req 1 sends 0xFF → res_count=0. Req 1 sends 0x5A → res_count=1.
- After reset, reqs 0 and 2 are both valid → grant 0 first, then 2. With 1 and 3 then valid and rr_ptr=3 → grant 3, then 1.
- Hold res_ready=0 for 5 cycles in RESP → res_valid, res_id and res_count stay stable, req_ready stays 0, busy=1. Release → IDLE on the next cycle.
- Assert rst during SHIFT → next cycle: IDLE, res_valid=0, busy=0. No result appears for the aborted word.
- With SEQ_MATCH_SCHED_TOTAL_EN: results 3, 1, 0 → total_matches=4. Reset → 0.

Source files
------------

// File: rtl/seq_match_sched.sv
// seq_match_sched: round-robin scheduler that time-shares one overlapping
// "1010" Moore detector among NREQ word sources. A granted word is shifted
// MSB-first through the detector, overlapping matches are counted, and the
// count is returned tagged with the requester index.
// Optional build macro: SEQ_MATCH_SCHED_TOTAL_EN adds o_total_matches, a
// 16-bit saturating sum of every result count handed to the consumer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate, offer req_ready to the winner, capture on accept
// ST_SHIFT | one word bit per cycle into the detector, MSB first
// ST_FLUSH | one cycle to count a match produced by the final bit
// ST_RESP  | hold res_valid/res_id/res_count until res_ready
module seq_match_sched #(
   parameter int NREQ   = 4,
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NREQ-1:0]           i_req_valid,
   input  logic [NREQ*WORD_W-1:0]    i_req_data,
   output logic [NREQ-1:0]           o_req_ready,
   output logic                      o_res_valid,
   output logic [$clog2(NREQ)-1:0]   o_res_id,
   output logic [CNT_W-1:0]          o_res_count,
   input  logic                      i_res_ready,
   output logic                      o_busy
`ifdef SEQ_MATCH_SCHED_TOTAL_EN
   ,
   output logic [15:0]               o_total_matches
`endif
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FLUSH = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      D_S0 = 3'd0,
      D_S1 = 3'd1,
      D_S2 = 3'd2,
      D_S3 = 3'd3,
      D_S4 = 3'd4
   } det_t;

   state_t              r_state;
   state_t              w_state_next;
   det_t                r_det;
   det_t                w_det_next;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     r_id;
   logic [WORD_W-1:0]   r_word;
   logic [BIT_W-1:0]    r_bit_idx;
   logic [CNT_W-1:0]    r_count;

   logic                w_found;
   logic [ID_W-1:0]     w_winner;
   logic [ID_W-1:0]     w_rr_next;
   logic                w_accept;
   logic [WORD_W-1:0]   w_win_word;
   logic                w_bit;
   logic                w_count_inc;

   // Round-robin search: first valid requester at or after r_rr_ptr, with wrap.
   always_comb begin
      logic [ID_W-1:0] idx;
      w_found  = 1'b0;
      w_winner = '0;
      idx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ID_W'((int'(r_rr_ptr) + k) % NREQ);
         if (!w_found && i_req_valid[idx]) begin
            w_found  = 1'b1;
            w_winner = idx;
         end
      end
   end

   assign w_rr_next  = (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
   assign w_accept   = (r_state == ST_IDLE) && w_found;
   assign w_win_word = i_req_data[int'(w_winner)*WORD_W +: WORD_W];
   assign w_bit      = r_word[r_bit_idx];

   // A match is visible one cycle after its last bit, so FLUSH catches the final one.
   assign w_count_inc = ((r_state == ST_SHIFT) || (r_state == ST_FLUSH)) &&
                        (r_det == D_S4) && (r_count != {CNT_W{1'b1}});

   // Overlapping "1010" detector transition function.
   always_comb begin
      w_det_next = D_S0;
      case (r_det)
         D_S0:    w_det_next = w_bit ? D_S1 : D_S0;
         D_S1:    w_det_next = w_bit ? D_S1 : D_S2;
         D_S2:    w_det_next = w_bit ? D_S3 : D_S0;
         D_S3:    w_det_next = w_bit ? D_S1 : D_S4;
         D_S4:    w_det_next = w_bit ? D_S3 : D_S0;
         default: w_det_next = D_S0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next-state logic; the bit index is a down-counter ending at zero.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_next = ST_SHIFT;
         ST_SHIFT: if (r_bit_idx == '0) w_state_next = ST_FLUSH;
         ST_FLUSH: w_state_next = ST_RESP;
         ST_RESP:  if (i_res_ready) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // FSM outputs; req_ready is held low while reset is asserted.
   always_comb begin
      o_req_ready = '0;
      if ((r_state == ST_IDLE) && w_found && !i_rst) o_req_ready[w_winner] = 1'b1;
      o_res_valid = (r_state == ST_RESP);
      o_busy      = (r_state != ST_IDLE);
   end

   assign o_res_id    = r_id;
   assign o_res_count = r_count;

   // Datapath: capture on accept, shift/detect/count, arbitration pointer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr_ptr  <= '0;
         r_id      <= '0;
         r_word    <= '0;
         r_bit_idx <= '0;
         r_count   <= '0;
         r_det     <= D_S0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_word    <= w_win_word;
                  r_id      <= w_winner;
                  r_det     <= D_S0;
                  r_count   <= '0;
                  r_bit_idx <= BIT_W'(WORD_W - 1);
                  r_rr_ptr  <= w_rr_next;
               end
            end
            ST_SHIFT: begin
               r_det <= w_det_next;
               if (w_count_inc) r_count <= r_count + 1'b1;
               if (r_bit_idx != '0) r_bit_idx <= r_bit_idx - 1'b1;
            end
            ST_FLUSH: begin
               if (w_count_inc) r_count <= r_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SEQ_MATCH_SCHED_TOTAL_EN
   logic [15:0] r_total;
   logic [16:0] w_total_sum;

   assign w_total_sum     = {1'b0, r_total} + 17'(r_count);
   assign o_total_matches = r_total;

   // Running total of delivered counts, saturating at 0xFFFF.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_total <= '0;
      else if ((r_state == ST_RESP) && i_res_ready)
         r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed bench for seq_match_sched (NREQ=4, WORD_W=8, CNT_W=4).
module tb_seq_match_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [3:0]  res_count;
   logic        res_ready;
   logic        busy;
`ifdef SEQ_MATCH_SCHED_TOTAL_EN
   logic [15:0] total_matches;
`endif

   int checks   = 0;
   int failures = 0;

   seq_match_sched #(.NREQ(4), .WORD_W(8), .CNT_W(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .o_res_valid (res_valid),
      .o_res_id    (res_id),
      .o_res_count (res_count),
      .i_res_ready (res_ready),
      .o_busy      (busy)
`ifdef SEQ_MATCH_SCHED_TOTAL_EN
      ,
      .o_total_matches (total_matches)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reset with all requesters valid; req_ready must stay low throughout.
   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 4'b1111;
      @(posedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res_count", 32'(res_count), 32'd0);
      rst       = 1'b0;
      req_valid = 4'b0000;
   endtask

   // One complete transaction; entered and left at posedge+1 in IDLE.
   task automatic xfer(input logic [3:0] valids, input int exp_id,
                       input logic [31:0] data_all, input logic [3:0] exp_cnt,
                       input int hold);
      req_valid = valids;
      req_data  = data_all;
      res_ready = (hold == 0);
      #1;
      chk("grant", 32'(req_ready), 32'd1 << exp_id);
      @(posedge clk); #1;
      req_valid[exp_id] = 1'b0;
      req_data = ~data_all;
      chk("busy_shift", 32'(busy), 32'd1);
      chk("ready_shift", 32'(req_ready), 32'd0);
      chk("res_valid_shift", 32'(res_valid), 32'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("res_valid_flush", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      chk("res_valid_resp", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(exp_id));
      chk("res_count", 32'(res_count), 32'(exp_cnt));
      if (hold > 0) begin
         req_valid = 4'b1111;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_id", 32'(res_id), 32'(exp_id));
            chk("hold_count", 32'(res_count), 32'(exp_cnt));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
         end
         res_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("res_valid_done", 32'(res_valid), 32'd0);
      chk("busy_done", 32'(busy), 32'd0);
      req_valid = 4'b0000;
      res_ready = 1'b1;
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      res_ready = 1'b1;
      do_reset();

      // Single-requester word patterns.
      xfer(4'b0001, 0, 32'h0000_00AA, 4'd3, 0);
      xfer(4'b0010, 1, 32'h0000_0A00, 4'd1, 0);
      xfer(4'b0010, 1, 32'h0000_FF00, 4'd0, 0);
`ifdef SEQ_MATCH_SCHED_TOTAL_EN
      chk("total_3_1_0", 32'(total_matches), 32'd4);
`endif
      xfer(4'b0010, 1, 32'h0000_5A00, 4'd1, 0);
`ifdef SEQ_MATCH_SCHED_TOTAL_EN
      chk("total_plus_1", 32'(total_matches), 32'd5);
`endif

      // Arbitration after reset: 0 then 2, then 3 then 1.
      do_reset();
`ifdef SEQ_MATCH_SCHED_TOTAL_EN
      chk("total_reset", 32'(total_matches), 32'd0);
`endif
      xfer(4'b0101, 0, 32'hAA14_FF0A, 4'd1, 0);
      xfer(4'b0100, 2, 32'hAA14_FF0A, 4'd1, 0);
      xfer(4'b1010, 3, 32'hAA14_FF0A, 4'd3, 0);
      xfer(4'b1010, 1, 32'hAA14_FF0A, 4'd0, 0);

      // Back-pressure in RESP for 5 cycles.
      xfer(4'b0001, 0, 32'h0000_005A, 4'd1, 5);

      // Reset during SHIFT drops the word and rewinds rr_ptr.
      req_valid = 4'b0010;
      req_data  = 32'h0000_AA00;
      #1;
      chk("abort_grant", 32'(req_ready), 32'd2);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy_pre", 32'(busy), 32'd1);
      rst       = 1'b1;
      req_valid = 4'b1111;
      @(posedge clk); #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_res_valid", 32'(res_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd0);
      rst       = 1'b0;
      req_valid = 4'b0000;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (res_valid || busy) seen++;
      end
      chk("abort_no_result", 32'(seen), 32'd0);
      xfer(4'b1111, 0, 32'h1111_11AA, 4'd3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
